// File: rtl/branch_predictor_table.sv
// Table of saturating-counter branch predictors indexed by fetch PC.
// Optional gshare history hashing is enabled by defining BP_GSHARE_EN.
module branch_predictor_table #(
    parameter int unsigned ENTRIES    = 64,
    parameter int unsigned CTR_WIDTH  = 2,
    parameter int unsigned HIST_WIDTH = 6,
    parameter int unsigned PC_WIDTH   = 32,
    localparam int unsigned IDX_W     = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] fetch_pc,
    output logic                prediction,
    output logic [IDX_W-1:0]    pred_idx,
    input  logic                update_valid,
    input  logic                stall,
    input  logic [IDX_W-1:0]    update_idx,
    input  logic                update_pred,
    input  logic                br_en,
    output logic [15:0]         mispredict_count
);

    localparam logic [CTR_WIDTH-1:0] CtrInit = CTR_WIDTH'(1 << (CTR_WIDTH - 1));
    localparam logic [CTR_WIDTH-1:0] CtrMax  = '1;

    logic [CTR_WIDTH-1:0] ctr_q [ENTRIES];
    logic [CTR_WIDTH-1:0] ctr_d [ENTRIES];
    logic [15:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]     base_idx;
    logic                 upd_en;

    assign base_idx = fetch_pc[IDX_W+1:2];
    assign upd_en   = update_valid & ~stall;

    logic unused_pc;
    assign unused_pc = ^{fetch_pc[PC_WIDTH-1:IDX_W+2], fetch_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [HIST_WIDTH-1:0] ghr_q, ghr_d;

    // History advances at resolution only, so it never needs repair.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_en) begin
            ghr_d = HIST_WIDTH'({ghr_q, br_en});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign pred_idx = base_idx ^ IDX_W'(ghr_q);
`else
    logic [HIST_WIDTH-1:0] unused_hist;
    assign unused_hist = '0;
    assign pred_idx    = base_idx;
`endif

    // Read sees registered state only: no bypass from a same-cycle update.
    assign prediction       = ctr_q[pred_idx][CTR_WIDTH-1];
    assign mispredict_count = cnt_q;

    always_comb begin
        ctr_d = ctr_q;
        if (upd_en) begin
            if (br_en) begin
                if (ctr_q[update_idx] != CtrMax) begin
                    ctr_d[update_idx] = ctr_q[update_idx] + CTR_WIDTH'(1);
                end
            end else begin
                if (ctr_q[update_idx] != '0) begin
                    ctr_d[update_idx] = ctr_q[update_idx] - CTR_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (upd_en && (update_pred != br_en) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CtrInit;
            end
            cnt_q <= '0;
        end else begin
            ctr_q <= ctr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
